fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- IF stage of the RV32I pipeline; producer side of the fetch/decode pipeline register.
- Holds the PC, addresses instruction memory and drives pcF/instF/stateF into the F->C register.
- Contains a direct-mapped BTB with 2-bit saturating counters and generates hit_predict1, a one-cycle-late taken prediction that squashes the wrong-path fetch.
- Accepts redirect and predictor updates from execute.

Parameters:
- PC_W, 13, PC width in bits (byte address, word aligned).
- IDX_W, 4, BTB index width; 2**IDX_W entries.
- INIT_PC, 13'd0, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  reset, synchronous, active-low.
- stall  in  1  hazard stall; hold PC and all fetch state.
- fail_predict  in  1  execute detected a mispredict; redirect.
- redirect_pc  in  PC_W  correct next PC when fail_predict=1.
- imem_addr  out  PC_W-2  word address to instruction memory (combinational read).
- imem_rdata  in  32  instruction word at imem_addr.
- pcF  out  PC_W  PC of the instruction being fetched.
- instF  out  32  fetched instruction.
- stateF  out  2  predictor counter for pcF, carried down the pipe.
- hit_predict1  out  1  previous fetch was predicted taken; the current fetch is wrong-path.
- upd_en  in  1  predictor update from execute, one per resolved branch.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target.
- upd_state  in  2  stateF value the branch was fetched with.

Behaviour:
- Reset (NRST=0 at posedge):
  - pc_q=INIT_PC; lookup_q=0; all BTB valid bits=0; all counters=2'b01.
  - Target RAM contents are don't-care.
- Outputs:
  - pcF=pc_q; imem_addr=pc_q[PC_W-1:2]; instF=imem_rdata (all combinational).
  - idx=pc_q[IDX_W+1:2]; tag=pc_q[PC_W-1:IDX_W+2]; hit=valid[idx] & (tag_arr[idx]==tag).
  - stateF = hit ? cnt[idx] : 2'b01.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit1=1.
- Prediction pipeline:
  - Valid/tag/counter arrays are flops read combinationally. The target array is a synchronous-read RAM.
  - On each unstalled edge: lookup_q <= hit & cnt[idx][1]; tgt_q <= target[idx].
  - hit_predict1 = lookup_q, driven combinationally from the flop, independent of stall.
- Next-PC priority, evaluated at each posedge:
  1. NRST=0: reset.
  2. fail_predict: pc_q<=redirect_pc; lookup_q<=0. Any pending hit_predict1 is cancelled.
  3. stall: pc_q, lookup_q and tgt_q all hold.
  4. lookup_q=1: pc_q<=tgt_q; lookup_q<=0. The redirected fetch is never itself flagged in the same cycle.
  5. Otherwise: pc_q<=pc_q+4, wrapping modulo 2**PC_W (8188 -> 0).
- Predictor update, applied at posedge when upd_en=1, independent of stall/fail_predict:
  - cnt[uidx] <= upd_taken ? sat_inc(upd_state) : sat_dec(upd_state). sat_inc(11)=11; sat_dec(00)=00.
  - If upd_taken: valid[uidx]<=1; tag_arr[uidx]<=utag; target[uidx]<=upd_target.
  - If not taken: valid, tag and target are unchanged.
  - Lookup and update of the same index in the same cycle: lookup sees the old contents (read-before-write). The new value is visible next cycle.
  - An update under reset is ignored.
- fail_predict and lookup_q both high: fail_predict wins.
- fail_predict during stall: the redirect still applies.
- Misaligned redirect_pc/upd_target: bits[1:0] are forced to 0.

Optional Feature:
- Macro: FETCH_BPRED_EN.
- Defined: BTB and counters as above.
- Undefined: static not-taken.
  - stateF is constant 2'b01; hit_predict1 is constant 0.
  - upd_* inputs are ignored; no BTB storage is synthesised.
  - Next-PC priority is unchanged minus step 4.

Test Plan:
1. Reset, then 4 unstalled cycles -> pcF sequence 0,4,8,12; imem_addr 0,1,2,3; stateF=01; hit_predict1=0.
2. upd_en with upd_pc=0x010, upd_taken=1, upd_state=01, upd_target=0x100; then run from reset -> stateF=10 at pcF=0x010. Next cycle: pcF=0x014 with hit_predict1=1. Following cycle: pcF=0x100, hit_predict1=0.
3. Scenario 2, but stall held 3 cycles while hit_predict1=1 -> pcF holds 0x014 and hit_predict1 stays 1. Redirect to 0x100 occurs on the first unstalled edge.
4. Scenario 2, but fail_predict=1 with redirect_pc=0x040 in the hit_predict1 cycle -> next pcF=0x040, hit_predict1=0.
5. Saturation: upd_state=11 taken -> cnt=11; upd_state=00 not-taken -> cnt=00. Not-taken update keeps valid=1 and the target intact.
6. PC at 8188, no stall -> next pcF=0. Same-cycle lookup and update of index 4 -> stateF shows the old counter that cycle and the new counter the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// IF stage of the RV32I pipeline: PC register, instruction fetch and a direct-mapped BTB.
// Define FETCH_BPRED_EN to build the BTB/2-bit predictor; otherwise fetch is static not-taken.
module fetch_unit #(
    parameter int unsigned     PC_W    = 13,
    parameter int unsigned     IDX_W   = 4,
    parameter logic [PC_W-1:0] INIT_PC = '0
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            stall,
    input  logic            fail_predict,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-3:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pcF,
    output logic [31:0]     instF,
    output logic [1:0]      stateF,
    output logic            hit_predict1,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic [1:0]      upd_state
);
    localparam logic [1:0] CNT_RST = 2'b01;

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  tgt_q;
    logic [PC_W-1:0]  redirect_al;
    logic [IDX_W-1:0] idx;
    logic             lookup_q;
    logic             lookup_d;
    logic             predict_c;
    logic             unused;

    assign redirect_al  = {redirect_pc[PC_W-1:2], 2'b00};
    assign idx          = pc_q[IDX_W+1:2];
    assign pcF          = pc_q;
    assign imem_addr    = pc_q[PC_W-1:2];
    assign instF        = imem_rdata;
    assign hit_predict1 = lookup_q;

    // Next-PC priority: mispredict redirect, stall, predicted target, sequential.
    always_comb begin
        pc_d     = pc_q;
        lookup_d = lookup_q;
        if (fail_predict) begin
            pc_d     = redirect_al;
            lookup_d = 1'b0;
        end else if (!stall) begin
            if (lookup_q) begin
                pc_d     = tgt_q;
                lookup_d = 1'b0;
            end else begin
                pc_d     = pc_q + PC_W'(4);
                lookup_d = predict_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            pc_q <= INIT_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_BPRED_EN
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] utag;
    logic [IDX_W-1:0] uidx;
    logic             hit;
    logic [1:0]       cnt_new;
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [1:0]       cnt_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];

    assign tag       = pc_q[PC_W-1:IDX_W+2];
    assign uidx      = upd_pc[IDX_W+1:2];
    assign utag      = upd_pc[PC_W-1:IDX_W+2];
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    assign predict_c = hit & cnt_q[idx][1];
    assign stateF    = hit ? cnt_q[idx] : CNT_RST;

    // Saturating counter step from the state the branch was fetched with.
    always_comb begin
        cnt_new = upd_state;
        if (upd_taken) begin
            if (upd_state != 2'b11) cnt_new = upd_state + 2'd1;
        end else begin
            if (upd_state != 2'b00) cnt_new = upd_state - 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            lookup_q <= 1'b0;
            tgt_q    <= '0;
        end else begin
            lookup_q <= lookup_d;
            if (!stall) tgt_q <= target_q[idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            valid_q <= '0;
            cnt_q   <= '{default: CNT_RST};
        end else if (upd_en) begin
            cnt_q[uidx] <= cnt_new;
            if (upd_taken) valid_q[uidx] <= 1'b1;
        end
    end

    // Tag and target need no reset: every entry is qualified by its valid bit.
    always_ff @(posedge CLK) begin
        if (NRST && upd_en && upd_taken) begin
            tag_q[uidx]    <= utag;
            target_q[uidx] <= {upd_target[PC_W-1:2], 2'b00};
        end
    end

    assign unused = ^{upd_pc[1:0], upd_target[1:0], redirect_pc[1:0]};
`else
    assign lookup_q  = 1'b0;
    assign tgt_q     = INIT_PC;
    assign predict_c = 1'b0;
    assign stateF    = CNT_RST;
    assign unused    = ^{idx, lookup_d, upd_en, upd_pc, upd_taken, upd_target,
                         upd_state, redirect_pc[1:0]};
`endif

endmodule
